// File: rtl/rotary_encoder_array.sv
// rtl/rotary_encoder_array.sv - multi-channel quadrature decoder: sync, debounce, detent FSM, position counters.
// Define ROTARY_SATURATE_EN to make position counters saturate instead of wrap.
module rotary_encoder_array #(
  parameter int CHANNELS        = 2,
  parameter int COUNT_W         = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*CHANNELS-1:0]         rotary_in,
  input  logic [CHANNELS-1:0]           clear,
  output logic [CHANNELS-1:0]           rotary_cw,
  output logic [CHANNELS-1:0]           rotary_ccw,
  output logic [CHANNELS*COUNT_W-1:0]   position
);

  localparam int NB = 2 * CHANNELS;
  localparam logic [15:0]        DEB     = 16'(DEBOUNCE_CYCLES);
  localparam logic [COUNT_W-1:0] POS_ONE = COUNT_W'(1);
`ifdef ROTARY_SATURATE_EN
  localparam logic [COUNT_W-1:0] POS_MAX = {1'b0, {(COUNT_W-1){1'b1}}};
  localparam logic [COUNT_W-1:0] POS_MIN = {1'b1, {(COUNT_W-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CW1, S_CW2, S_CW3, S_CCW1, S_CCW2, S_CCW3, S_RESYNC
  } state_t;

  logic [NB-1:0]        sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [15:0]          cnt_q [NB];
  logic [15:0]          cnt_d [NB];
  state_t               state_q [CHANNELS];
  state_t               state_d [CHANNELS];
  logic [CHANNELS-1:0]  cw_q, cw_d, ccw_q, ccw_d;
  logic [COUNT_W-1:0]   pos_q [CHANNELS];
  logic [COUNT_W-1:0]   pos_d [CHANNELS];

  // A change is seen as it moves into the second sync stage, so the filtered
  // bit follows a clean raw edge after exactly 2 + DEBOUNCE_CYCLES edges.
  always_comb begin
    sync1_d = rotary_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync1_q[i] != sync2_q[i]) begin
        cnt_d[i] = '0;
      end else begin
        if (cnt_q[i] != DEB) cnt_d[i] = cnt_q[i] + 16'd1;
        if (({1'b0, cnt_q[i]} + 17'd1) >= {1'b0, DEB}) filt_d[i] = sync2_q[i];
      end
    end
  end

  always_comb begin
    logic [1:0] ab;
    for (int c = 0; c < CHANNELS; c++) begin
      ab          = filt_q[2*c +: 2];
      state_d[c]  = state_q[c];
      cw_d[c]     = 1'b0;
      ccw_d[c]    = 1'b0;
      case (state_q[c])
        S_IDLE: begin
          if      (ab == 2'b01) state_d[c] = S_CW1;
          else if (ab == 2'b10) state_d[c] = S_CCW1;
          else if (ab == 2'b11) state_d[c] = S_RESYNC;
        end
        S_CW1: begin
          if      (ab == 2'b11) state_d[c] = S_CW2;
          else if (ab == 2'b00) state_d[c] = S_IDLE;
          else if (ab == 2'b10) state_d[c] = S_RESYNC;
        end
        S_CW2: begin
          if      (ab == 2'b10) state_d[c] = S_CW3;
          else if (ab == 2'b01) state_d[c] = S_CW1;
          else if (ab == 2'b00) state_d[c] = S_RESYNC;
        end
        S_CW3: begin
          if (ab == 2'b00) begin
            state_d[c] = S_IDLE;
            cw_d[c]    = 1'b1;
          end
          else if (ab == 2'b11) state_d[c] = S_CW2;
          else if (ab == 2'b01) state_d[c] = S_RESYNC;
        end
        S_CCW1: begin
          if      (ab == 2'b11) state_d[c] = S_CCW2;
          else if (ab == 2'b00) state_d[c] = S_IDLE;
          else if (ab == 2'b01) state_d[c] = S_RESYNC;
        end
        S_CCW2: begin
          if      (ab == 2'b01) state_d[c] = S_CCW3;
          else if (ab == 2'b10) state_d[c] = S_CCW1;
          else if (ab == 2'b00) state_d[c] = S_RESYNC;
        end
        S_CCW3: begin
          if (ab == 2'b00) begin
            state_d[c] = S_IDLE;
            ccw_d[c]   = 1'b1;
          end
          else if (ab == 2'b11) state_d[c] = S_CCW2;
          else if (ab == 2'b10) state_d[c] = S_RESYNC;
        end
        S_RESYNC: begin
          if (ab == 2'b00) state_d[c] = S_IDLE;
        end
        default: state_d[c] = S_RESYNC;
      endcase
    end
  end

  // Clear wins over a coincident event; the event pulse is still emitted.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      pos_d[c] = pos_q[c];
      if (clear[c]) begin
        pos_d[c] = '0;
      end else if (cw_d[c]) begin
`ifdef ROTARY_SATURATE_EN
        if (pos_q[c] != POS_MAX) pos_d[c] = pos_q[c] + POS_ONE;
`else
        pos_d[c] = pos_q[c] + POS_ONE;
`endif
      end else if (ccw_d[c]) begin
`ifdef ROTARY_SATURATE_EN
        if (pos_q[c] != POS_MIN) pos_d[c] = pos_q[c] - POS_ONE;
`else
        pos_d[c] = pos_q[c] - POS_ONE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      cw_q    <= '0;
      ccw_q   <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= S_IDLE;
        pos_q[c]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cw_q    <= cw_d;
      ccw_q   <= ccw_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        pos_q[c]   <= pos_d[c];
      end
    end
  end

  always_comb begin
    position = '0;
    for (int c = 0; c < CHANNELS; c++) position[c*COUNT_W +: COUNT_W] = pos_q[c];
  end

  assign rotary_cw  = cw_q;
  assign rotary_ccw = ccw_q;

endmodule

// File: tb/tb_rotary_encoder_array.sv
// tb/tb_rotary_encoder_array.sv - directed bench for rotary_encoder_array (2ch/8b and 1ch/4b instances).
module tb_rotary_encoder_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rin;
  logic [1:0]  clr;
  logic [1:0]  cw, ccw;
  logic [15:0] pos;
  logic [1:0]  rin2;
  logic        clr2;
  logic        cw2, ccw2;
  logic [3:0]  pos2;

  int n_tests = 0;
  int n_fail  = 0;
  int cw_cnt [2];
  int ccw_cnt [2];
  int cw2_cnt, ccw2_cnt, both_cnt, step_tick, cw0_tick;

  always #5 clk = ~clk;

  rotary_encoder_array #(.CHANNELS(2), .COUNT_W(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .rotary_in(rin), .clear(clr),
    .rotary_cw(cw), .rotary_ccw(ccw), .position(pos)
  );

  rotary_encoder_array #(.CHANNELS(1), .COUNT_W(4), .DEBOUNCE_CYCLES(4)) dut_w4 (
    .clk(clk), .reset(reset), .rotary_in(rin2), .clear(clr2),
    .rotary_cw(cw2), .rotary_ccw(ccw2), .position(pos2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    cw_cnt[0] = 0; cw_cnt[1] = 0; ccw_cnt[0] = 0; ccw_cnt[1] = 0;
    cw2_cnt = 0; ccw2_cnt = 0; both_cnt = 0; cw0_tick = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      step_tick++;
      if (cw[0]) begin cw_cnt[0]++; cw0_tick = step_tick; end
      if (cw[1])  cw_cnt[1]++;
      if (ccw[0]) ccw_cnt[0]++;
      if (ccw[1]) ccw_cnt[1]++;
      if (cw2)    cw2_cnt++;
      if (ccw2)   ccw2_cnt++;
      if ((cw[0] && ccw[0]) || (cw[1] && ccw[1])) both_cnt++;
    end
  endtask

  task automatic set_ab(input int ch, input logic [1:0] ab, input int n);
    rin[2*ch +: 2] = ab;
    step_tick = 0;
    tick(n);
  endtask

  task automatic set_both(input logic [3:0] v, input int n);
    rin = v;
    step_tick = 0;
    tick(n);
  endtask

  task automatic cw_detent(input int ch);
    set_ab(ch, 2'b01, 10); set_ab(ch, 2'b11, 10);
    set_ab(ch, 2'b10, 10); set_ab(ch, 2'b00, 10);
  endtask

  task automatic ccw_detent(input int ch);
    set_ab(ch, 2'b10, 10); set_ab(ch, 2'b11, 10);
    set_ab(ch, 2'b01, 10); set_ab(ch, 2'b00, 10);
  endtask

  task automatic set2(input logic [1:0] ab);
    rin2 = ab;
    tick(10);
  endtask

  initial begin
    reset = 1'b1; rin = '0; clr = '0; rin2 = '0; clr2 = 1'b0;
    step_tick = 0;
    clear_counts();
    tick(3);
    check("reset_pos",  32'(pos), 32'h0);
    check("reset_cw",   32'(cw),  32'h0);
    check("reset_ccw",  32'(ccw), 32'h0);
    check("reset_pos2", 32'(pos2), 32'h0);
    reset = 1'b0;
    tick(2);

    // single CW detent on ch0
    clear_counts();
    set_ab(0, 2'b01, 10); set_ab(0, 2'b11, 10); set_ab(0, 2'b10, 10);
    cw0_tick = -1;
    set_ab(0, 2'b00, 10);
    check("cw_count",   32'(cw_cnt[0]), 32'd1);
    check("cw_latency", 32'(cw0_tick),  32'd7);
    check("cw_pos0",    32'(pos[7:0]),  32'h01);
    check("cw_pos1",    32'(pos[15:8]), 32'h00);
    check("cw_no_ccw",  32'(ccw_cnt[0] + ccw_cnt[1]), 32'd0);

    // three CCW detents on ch1
    clear_counts();
    repeat (3) ccw_detent(1);
    check("ccw_count",  32'(ccw_cnt[1]), 32'd3);
    check("ccw_no_cw",  32'(cw_cnt[1]),  32'd0);
    check("ccw_pos1",   32'(pos[15:8]),  32'hFD);
    check("ccw_pos0",   32'(pos[7:0]),   32'h01);

    // 3-cycle glitch on ch0 A must be filtered out
    clear_counts();
    set_ab(0, 2'b01, 3); set_ab(0, 2'b00, 20);
    check("glitch_pulses", 32'(cw_cnt[0] + ccw_cnt[0]), 32'd0);
    check("glitch_pos0",   32'(pos[7:0]), 32'h01);
    cw_detent(0);
    check("glitch_then_cw", 32'(cw_cnt[0]), 32'd1);
    check("glitch_pos0_b",  32'(pos[7:0]),  32'h02);

    // reversal mid-detent returns to IDLE without an event
    clear_counts();
    set_ab(0, 2'b01, 10); set_ab(0, 2'b11, 10); set_ab(0, 2'b01, 10); set_ab(0, 2'b00, 10);
    check("rev_pulses", 32'(cw_cnt[0] + ccw_cnt[0]), 32'd0);
    cw_detent(0);
    check("rev_then_cw", 32'(cw_cnt[0]), 32'd1);
    check("rev_pos0",    32'(pos[7:0]),  32'h03);

    // 00->11 jump goes to RESYNC, recovers only on 00
    clear_counts();
    set_ab(0, 2'b11, 10); set_ab(0, 2'b10, 10); set_ab(0, 2'b00, 10);
    check("resync_pulses", 32'(cw_cnt[0] + ccw_cnt[0]), 32'd0);
    check("resync_pos0",   32'(pos[7:0]), 32'h03);
    cw_detent(0);
    check("resync_then_cw", 32'(cw_cnt[0]), 32'd1);
    check("resync_pos0_b",  32'(pos[7:0]),  32'h04);

    // simultaneous CW on ch0 and CCW on ch1
    clear_counts();
    set_both(4'b10_01, 10); set_both(4'b11_11, 10);
    set_both(4'b01_10, 10); set_both(4'b00_00, 10);
    check("simul_cw0",  32'(cw_cnt[0]),  32'd1);
    check("simul_ccw1", 32'(ccw_cnt[1]), 32'd1);
    check("simul_pos0", 32'(pos[7:0]),   32'h05);
    check("simul_pos1", 32'(pos[15:8]),  32'hFC);
    check("never_both", 32'(both_cnt),   32'd0);

    // clear coincident with a CW event
    clear_counts();
    set_ab(0, 2'b01, 10); set_ab(0, 2'b11, 10); set_ab(0, 2'b10, 10);
    set_ab(0, 2'b00, 6);
    clr[0] = 1'b1;
    tick(1);
    check("clr_pulse", 32'(cw[0]),    32'd1);
    check("clr_pos0",  32'(pos[7:0]), 32'h00);
    clr[0] = 1'b0;
    tick(5);
    check("clr_cw_count", 32'(cw_cnt[0]), 32'd1);
    check("clr_pos1",     32'(pos[15:8]), 32'hFC);

    // reset while in CW2 discards the partial detent
    set_ab(0, 2'b01, 10); set_ab(0, 2'b11, 10);
    reset = 1'b1;
    tick(1);
    check("rst_mid_pos", 32'(pos), 32'h0);
    check("rst_mid_cw",  32'(cw),  32'h0);
    check("rst_mid_ccw", 32'(ccw), 32'h0);
    reset = 1'b0;
    clear_counts();
    set_ab(0, 2'b11, 10); set_ab(0, 2'b10, 10); set_ab(0, 2'b00, 10);
    check("rst_mid_no_pulse", 32'(cw_cnt[0] + ccw_cnt[0]), 32'd0);
    check("rst_mid_pos_b",    32'(pos), 32'h0);

    // 4-bit counter: wrap or saturate at the positive limit
    clear_counts();
    repeat (7) begin set2(2'b01); set2(2'b11); set2(2'b10); set2(2'b00); end
    check("w4_pos7",  32'(pos2),    32'h7);
    check("w4_cw7",   32'(cw2_cnt), 32'd7);
    set2(2'b01); set2(2'b11); set2(2'b10); set2(2'b00);
    check("w4_cw8",   32'(cw2_cnt), 32'd8);
`ifdef ROTARY_SATURATE_EN
    check("w4_limit", 32'(pos2), 32'h7);
`else
    check("w4_limit", 32'(pos2), 32'h8);
`endif
    set2(2'b10); set2(2'b11); set2(2'b01); set2(2'b00);
    check("w4_ccw1",  32'(ccw2_cnt), 32'd1);
`ifdef ROTARY_SATURATE_EN
    check("w4_back", 32'(pos2), 32'h6);
`else
    check("w4_back", 32'(pos2), 32'h7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rotary_encoder_array.md
ROTARY_ENCODER_ARRAY -- requirements
Module: rotary_encoder_array

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent quadrature encoder channels (1..8).
REQ-002 Parameter COUNT_W, default 8: width of each signed position counter (2..16).
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a filtered input bit changes (1..65535).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rotary_in  in  2*CHANNELS  raw encoder pins; channel n uses bits [2n+1:2n], bit 2n = A, bit 2n+1 = B; asynchronous to clk.
REQ-007 clear  in  CHANNELS  per-channel synchronous position clear, level-sampled each cycle.
REQ-008 rotary_cw  out  CHANNELS  one-cycle pulse per completed clockwise detent.
REQ-009 rotary_ccw  out  CHANNELS  one-cycle pulse per completed counter-clockwise detent.
REQ-010 position  out  CHANNELS*COUNT_W  signed two's-complement counters; channel n at [(n+1)*COUNT_W-1 : n*COUNT_W].

Function
REQ-011 Each rotary_in bit passes through a 2-flop synchroniser before any other logic.
REQ-012 Debounce per bit: a counter resets whenever the synchronised bit differs from its previous synchronised value; the filtered bit takes the synchronised value when the bit has been stable for DEBOUNCE_CYCLES consecutive cycles.
REQ-013 Per-channel FSM on filtered AB (A is LSB), states: IDLE(00), CW1(01), CW2(11), CW3(10), CCW1(10), CCW2(11), CCW3(01), RESYNC.
REQ-014 Forward transitions: IDLE->CW1 on 01, CW1->CW2 on 11, CW2->CW3 on 10, CW3->IDLE on 00 with CW event; IDLE->CCW1 on 10, CCW1->CCW2 on 11, CCW2->CCW3 on 01, CCW3->IDLE on 00 with CCW event.
REQ-015 Reversal: each CWk/CCWk state returns to its predecessor (IDLE for k=1) when AB returns to the predecessor code; no event.
REQ-016 Any other AB change (both bits changing in one cycle, or a code not listed) moves the FSM to RESYNC, no event; RESYNC->IDLE when AB=00.
REQ-017 FSM holds state while AB is unchanged.
REQ-018 rotary_cw/rotary_ccw are registered and high for exactly one cycle, the cycle after the FSM takes the event transition; never both high on a channel.
REQ-019 Latency: a clean raw level change held stable reaches the filtered bit after 2 + DEBOUNCE_CYCLES cycles; the corresponding event pulse follows one cycle later.
REQ-020 position increments by 1 on a CW event and decrements by 1 on a CCW event, updated in the same cycle the pulse is asserted.
REQ-021 clear[n] high forces position channel n to 0 on the next edge; clear takes priority over a simultaneous event, whose pulse is still emitted.
REQ-022 Channels are fully independent; simultaneous events on different channels are all honoured.

Reset
REQ-023 reset high: synchronisers and filtered bits load 2'b00... per channel 00, debounce counters 0, FSMs IDLE, position 0, rotary_cw/rotary_ccw 0, on the next edge.
REQ-024 reset mid-rotation discards partial sequences; post-reset the FSM restarts from IDLE and no event is emitted for the interrupted detent.
REQ-025 Outputs are defined (0) from the first edge with reset high; no output depends on pre-reset state.

Configuration
REQ-026 Macro ROTARY_SATURATE_EN defined: position saturates at +(2^(COUNT_W-1)-1) and -(2^(COUNT_W-1)); events beyond the limit still pulse but do not change position.
REQ-027 Macro ROTARY_SATURATE_EN undefined: position wraps modulo 2^COUNT_W (max +1 -> min, min -1 -> max).

Verification
REQ-028 CHANNELS=2, DEBOUNCE_CYCLES=4: drive ch0 AB 00->01->11->10->00, each held 10 cycles -> one rotary_cw[0] pulse 7 cycles after the final 00 is applied; position ch0 = 1; ch1 unchanged.
REQ-029 Same setup, ch1 sequence 00->10->11->01->00 three times -> three rotary_ccw[1] pulses, position ch1 = -3 (8'hFD).
REQ-030 Glitch: toggle ch0 A for 3 cycles then restore, DEBOUNCE_CYCLES=4 -> no FSM change, no pulse, position unchanged.
REQ-031 Reversal: 00->01->11->01->00 -> no pulse, FSM back to IDLE; jump 00->11 -> RESYNC, no pulse until 00 seen.
REQ-032 COUNT_W=4, 7 CW detents then 1 more: without ROTARY_SATURATE_EN position = -8; with it position = 7, pulse still asserted.
REQ-033 Assert clear[0] in the cycle a CW event completes -> rotary_cw[0] pulses, position ch0 = 0; assert reset during CW2 -> all outputs 0 next edge, no pulse on subsequent 10->00.
